// File: rtl/muldiv_seq.sv
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M multiply/divide sequencer. Accepts one
//                M-extension operation (funct3-encoded), runs it on a
//                shift-add / restoring-subtract datapath at one bit per
//                cycle, and holds the pipeline stalled until the result is
//                ready.
//                Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero,
//                signed divide overflow and MUL* with a zero operand skip
//                the iteration and finish straight from PREP.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [CW-1:0]   c_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PREP = 3'd1;
    localparam logic [2:0] c_RUN  = 3'd2;
    localparam logic [2:0] c_FIX  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_f3;       // operation captured on accept
    logic [XLEN-1:0] r_op_a;     // raw rs1 captured on accept
    logic [XLEN-1:0] r_op_b;     // raw rs2 captured on accept
    logic [XLEN-1:0] r_mcand;    // |multiplicand| or |divisor|
    logic [XLEN-1:0] r_hi;       // product high half / partial remainder
    logic [XLEN-1:0] r_lo;       // multiplier->product low half / dividend->quotient
    logic            r_neg;      // final magnitude must be negated
    logic [XLEN-1:0] r_result;

    // ------------------------------------------------------------------------
    // Operand decode (all from captured values, so srcA/srcB may move freely)
    // ------------------------------------------------------------------------
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic            w_early;
    logic [XLEN-1:0] w_special_val;

    // MUL/MULH treat both operands as signed, MULHSU only rs1, MULHU neither;
    // DIV/REM are signed, DIVU/REMU unsigned.
    assign w_is_div   = r_f3[2];
    assign w_a_signed = w_is_div ? ~r_f3[0] : (r_f3[1:0] != 2'b11);
    assign w_b_signed = w_is_div ? ~r_f3[0] : ~r_f3[1];
    assign w_sa       = w_a_signed & r_op_a[XLEN-1];
    assign w_sb       = w_b_signed & r_op_b[XLEN-1];
    assign w_mag_a    = w_sa ? -r_op_a : r_op_a;
    assign w_mag_b    = w_sb ? -r_op_b : r_op_b;

    assign w_div_zero = w_is_div & (r_op_b == {XLEN{1'b0}});
    assign w_div_ovf  = w_is_div & ~r_f3[0] & (r_op_a == c_MIN)
                      & (r_op_b == {XLEN{1'b1}});

`ifdef MULDIV_EARLY_OUT_EN
    logic w_mul_zero;
    // A zero MUL* operand makes every product word zero, so it can finish early.
    assign w_mul_zero = ~w_is_div & ((r_op_a == {XLEN{1'b0}}) | (r_op_b == {XLEN{1'b0}}));
    assign w_special  = w_div_zero | w_div_ovf | w_mul_zero;
    assign w_early    = w_special;
`else
    assign w_special  = w_div_zero | w_div_ovf;
    assign w_early    = 1'b0;
`endif

    // Architectural results for the RISC-V corner cases (no trap is raised).
    always_comb begin
        w_special_val = {XLEN{1'b0}};
        if (w_div_zero) begin
            w_special_val = r_f3[1] ? r_op_a : {XLEN{1'b1}};
        end else if (w_div_ovf) begin
            w_special_val = r_f3[1] ? {XLEN{1'b0}} : c_MIN;
        end
    end

    // ------------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------------
    logic [XLEN:0]   w_add;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;

    // Multiply: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole {carry,hi,lo} right by one.
    assign w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});

    // Divide: shift the next dividend bit into the remainder and try to
    // subtract the divisor; a clear borrow bit means the quotient bit is 1.
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_mcand};

    // ------------------------------------------------------------------------
    // Final sign / word selection
    // ------------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_mul_word;
    logic [XLEN-1:0]   w_div_mag;
    logic [XLEN-1:0]   w_div_s;
    logic [XLEN-1:0]   w_final;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_s   = r_neg ? -w_prod : w_prod;
    assign w_mul_word = (r_f3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    assign w_div_mag  = r_f3[1] ? r_hi : r_lo;
    assign w_div_s    = r_neg ? -w_div_mag : w_div_mag;
    assign w_final    = w_special ? w_special_val : (w_is_div ? w_div_s : w_mul_word);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush returns any active state to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start && !flush) begin
                    w_next = c_PREP;
                end
            end
            c_PREP: begin
                if (flush) begin
                    w_next = c_IDLE;
                end else if (w_early) begin
                    w_next = c_DONE;
                end else begin
                    w_next = c_RUN;
                end
            end
            c_RUN: begin
                if (flush) begin
                    w_next = c_IDLE;
                end else if (r_cnt == c_LAST) begin
                    w_next = c_FIX;
                end
            end
            c_FIX: begin
                w_next = flush ? c_IDLE : c_DONE;
            end
            c_DONE: begin
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // Status outputs; stall also covers the request cycle itself.
    always_comb begin
        busy  = (r_state != c_IDLE);
        done  = (r_state == c_DONE);
        stall = (start & (r_state == c_IDLE) & ~flush)
              | ((r_state != c_IDLE) & (r_state != c_DONE));
    end

    assign result = r_result;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Operand capture, magnitude preparation and the per-bit iteration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= {CW{1'b0}};
            r_f3    <= 3'b000;
            r_op_a  <= {XLEN{1'b0}};
            r_op_b  <= {XLEN{1'b0}};
            r_mcand <= {XLEN{1'b0}};
            r_hi    <= {XLEN{1'b0}};
            r_lo    <= {XLEN{1'b0}};
            r_neg   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start && !flush) begin
                        r_f3   <= funct3;
                        r_op_a <= srcA;
                        r_op_b <= srcB;
                    end
                end
                c_PREP: begin
                    r_cnt <= {CW{1'b0}};
                    r_hi  <= {XLEN{1'b0}};
                    // Remainder takes the dividend's sign; everything else
                    // takes the XOR of the operand signs.
                    r_neg <= (w_is_div && r_f3[1]) ? w_sa : (w_sa ^ w_sb);
                    if (w_is_div) begin
                        r_mcand <= w_mag_b;
                        r_lo    <= w_mag_a;
                    end else begin
                        r_mcand <= w_mag_a;
                        r_lo    <= w_mag_b;
                    end
                end
                c_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_is_div) begin
                        if (!w_diff[XLEN]) begin
                            r_hi <= w_diff[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_hi <= w_shift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= w_add[XLEN:1];
                        r_lo <= {w_add[0], r_lo[XLEN-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result register: loads only on the transition into DONE, so a flushed
    // operation leaves the previous result in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= {XLEN{1'b0}};
        end else if ((r_state != c_DONE) && (w_next == c_DONE)) begin
            r_result <= w_final;
        end
    end

endmodule

`default_nettype wire
